// File: rtl/data_c_frame_concat.sv
// -----------------------------------------------------------------------------
// data_c_frame_concat
//
// Merges up to NUM ordered input segments (segment 0 first) into one output
// frame. A run-time mask picks which segments take part in each frame; the
// mask is latched at frame start and held for the whole frame. Output goes
// through a 2-entry in-order skid stage so one beat per cycle is sustained
// and s_ready depends only on registers (state, cur, occupancy).
//
// Parameters:
//   NUM   number of input segments (2..8)
//   DSIZE data width in bits
//
// Ports:
//   clock      rising-edge clock
//   rst_n      asynchronous active-low reset
//   seg_mask   segment enable mask, sampled at frame start
//   s_data     segment i data at [i*DSIZE +: DSIZE]
//   s_valid    per-segment valid
//   s_last     per-segment last beat of that segment
//   s_ready    per-segment ready (only the current segment is ever ready)
//   m_data     output data
//   m_valid    output valid
//   m_last     final beat of the frame
//   m_seg      source segment index of the current output beat
//   m_ready    output ready
//   frame_cnt  completed-frame counter (only with DATA_C_FRAME_CONCAT_FCNT_EN)
//
// Optional feature macro: DATA_C_FRAME_CONCAT_FCNT_EN
//
// States:
//   IDLE | no frame in progress, waiting for a nonzero seg_mask
//   RUN  | forwarding beats of segment cur within the latched mask_r
// -----------------------------------------------------------------------------
module data_c_frame_concat #(
    parameter int NUM   = 3,
    parameter int DSIZE = 32,
    localparam int SW   = (NUM > 2) ? $clog2(NUM) : 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NUM-1:0]       seg_mask,
    input  logic [NUM*DSIZE-1:0] s_data,
    input  logic [NUM-1:0]       s_valid,
    input  logic [NUM-1:0]       s_last,
    output logic [NUM-1:0]       s_ready,
    output logic [DSIZE-1:0]     m_data,
    output logic                 m_valid,
    output logic                 m_last,
    output logic [SW-1:0]        m_seg,
    input  logic                 m_ready
`ifdef DATA_C_FRAME_CONCAT_FCNT_EN
   ,output logic [15:0]          frame_cnt
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [SW-1:0]    cur;
    logic [NUM-1:0]   mask_r;

    logic [1:0]       occ;
    logic [DSIZE-1:0] buf_data;
    logic [SW-1:0]    buf_seg;
    logic             buf_last;

    logic             push;
    logic             pop;
    logic [DSIZE-1:0] in_data;
    logic             in_last;
    logic             higher;
    logic             frame_last;

    function automatic logic [SW-1:0] lowest_set(input logic [NUM-1:0] m);
        logic [SW-1:0] r;
        r = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (m[i]) r = SW'(i);
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] next_set(input logic [NUM-1:0] m,
                                               input logic [SW-1:0]  c);
        logic [SW-1:0] r;
        r = c;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (m[i] && (SW'(i) > c)) r = SW'(i);
        end
        return r;
    endfunction

    // Ready is a pure decode of registers, so there is no path from m_ready.
    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NUM; i++) begin
            s_ready[i] = (state == RUN) && (occ != 2'd2) && (cur == SW'(i));
        end
    end

    always_comb begin
        in_data = '0;
        in_last = 1'b0;
        higher  = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (cur == SW'(i)) begin
                in_data = s_data[i*DSIZE +: DSIZE];
                in_last = s_last[i];
            end
            if (mask_r[i] && (SW'(i) > cur)) higher = 1'b1;
        end
    end

    assign push       = |(s_valid & s_ready);
    assign pop        = m_valid && m_ready;
    assign frame_last = in_last && !higher;
    assign m_valid    = (occ != 2'd0);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cur    <= '0;
            mask_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|seg_mask) begin
                        mask_r <= seg_mask;
                        cur    <= lowest_set(seg_mask);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (push && in_last) begin
                        if (higher) begin
                            cur <= next_set(mask_r, cur);
                        end else if (|seg_mask) begin
                            // Back-to-back frame: re-latch without a bubble.
                            mask_r <= seg_mask;
                            cur    <= lowest_set(seg_mask);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid stage: m_* is the head entry, buf_* holds the second entry.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= 2'd0;
            m_data   <= '0;
            m_seg    <= '0;
            m_last   <= 1'b0;
            buf_data <= '0;
            buf_seg  <= '0;
            buf_last <= 1'b0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        m_data <= in_data;
                        m_seg  <= cur;
                        m_last <= frame_last;
                        occ    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        m_data <= in_data;
                        m_seg  <= cur;
                        m_last <= frame_last;
                    end else if (push) begin
                        buf_data <= in_data;
                        buf_seg  <= cur;
                        buf_last <= frame_last;
                        occ      <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                default: begin
                    // Full: no push is possible, only drain the buffer.
                    if (pop) begin
                        m_data <= buf_data;
                        m_seg  <= buf_seg;
                        m_last <= buf_last;
                        occ    <= 2'd1;
                    end
                end
            endcase
        end
    end

`ifdef DATA_C_FRAME_CONCAT_FCNT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (m_valid && m_ready && m_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_c_frame_concat.sv
module tb_data_c_frame_concat;

    localparam int NUM   = 3;
    localparam int DSIZE = 32;
    localparam int SW    = 2;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic [SW-1:0]    seg;
        logic             last;
    } beat_t;

    typedef struct {
        logic [NUM-1:0] mask;
        int             n0;
        int             n1;
        int             n2;
        int             exp_beats;
        int             exp_seg;
    } vec_t;

    logic                 clock = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM-1:0]       seg_mask = '0;
    logic [NUM*DSIZE-1:0] s_data;
    logic [NUM-1:0]       s_valid;
    logic [NUM-1:0]       s_last;
    logic [NUM-1:0]       s_ready;
    logic [DSIZE-1:0]     m_data;
    logic                 m_valid;
    logic                 m_last;
    logic [SW-1:0]        m_seg;
    logic                 m_ready = 1'b0;
`ifdef DATA_C_FRAME_CONCAT_FCNT_EN
    logic [15:0]          frame_cnt;
`endif

    data_c_frame_concat #(.NUM(NUM), .DSIZE(DSIZE)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .seg_mask (seg_mask),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_seg    (m_seg),
        .m_ready  (m_ready)
`ifdef DATA_C_FRAME_CONCAT_FCNT_EN
       ,.frame_cnt(frame_cnt)
`endif
    );

    always #5 clock = ~clock;

    logic [DSIZE:0] src_q [NUM][$];
    beat_t          exp_q[$];

    int checks = 0;
    int errors = 0;
    int nbeats = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int first_seg = 0;
    int last_seg = 0;
    int acc_cnt = 0;
    logic [NUM-1:0] saw_ready = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Source drivers: a beat leaves its queue once the handshake completes.
    initial begin
        logic [NUM-1:0] acc;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        forever begin
            @(negedge clock);
            acc = s_valid & s_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < NUM; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    acc_cnt++;
                end
                if (src_q[i].size() > 0) begin
                    s_valid[i] = 1'b1;
                    s_data[i*DSIZE +: DSIZE] = src_q[i][0][DSIZE:1];
                    s_last[i] = src_q[i][0][0];
                end else begin
                    s_valid[i] = 1'b0;
                    s_last[i]  = 1'b0;
                end
            end
        end
    end

    // Output monitor with scoreboard.
    initial begin
        beat_t got;
        beat_t e;
        forever begin
            @(negedge clock);
            cyc++;
            saw_ready = saw_ready | s_ready;
            if (m_valid && m_ready) begin
                got = {m_data, m_seg, m_last};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual data=%h seg=%0d last=%0d required none",
                             m_data, m_seg, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL beat actual data=%h seg=%0d last=%0d required data=%h seg=%0d last=%0d",
                                 got.data, got.seg, got.last, e.data, e.seg, e.last);
                    end
                end
                nbeats++;
                if (nbeats == 1) begin
                    first_cyc = cyc;
                    first_seg = int'(m_seg);
                end
                last_cyc = cyc;
                last_seg = int'(m_seg);
            end
        end
    end

    task automatic load_frame(input logic [NUM-1:0] mask, input int n0, input int n1,
                              input int n2, input logic [31:0] base);
        int n[NUM];
        int top;
        logic [DSIZE-1:0] d;
        logic lst;
        n[0] = n0;
        n[1] = n1;
        n[2] = n2;
        top = 0;
        for (int i = 0; i < NUM; i++) if (mask[i]) top = i;
        for (int i = 0; i < NUM; i++) begin
            for (int j = 0; j < n[i]; j++) begin
                d   = base + 32'(i * 256 + j);
                lst = (j == n[i] - 1);
                src_q[i].push_back({d, lst});
                if (mask[i]) exp_q.push_back({d, SW'(i), lst && (i == top)});
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        rst_n    = 1'b0;
        seg_mask = '0;
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        exp_q.delete();
        repeat (3) @(posedge clock);
        #1;
        rst_n     = 1'b1;
        nbeats    = 0;
        saw_ready = '0;
        acc_cnt   = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d required=0 beats pending", name, exp_q.size());
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (nbeats < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (nbeats < n) begin
            errors++;
            $display("FAIL wait_beats actual=%0d required=%0d", nbeats, n);
        end
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{mask: 3'b111, n0: 2, n1: 4, n2: 1, exp_beats: 7, exp_seg: 2};
        vt[1] = '{mask: 3'b101, n0: 3, n1: 2, n2: 2, exp_beats: 5, exp_seg: 2};
        vt[2] = '{mask: 3'b011, n0: 1, n1: 1, n2: 0, exp_beats: 2, exp_seg: 1};
        vt[3] = '{mask: 3'b010, n0: 0, n1: 3, n2: 0, exp_beats: 3, exp_seg: 1};
        vt[4] = '{mask: 3'b100, n0: 0, n1: 0, n2: 1, exp_beats: 1, exp_seg: 2};
        vt[5] = '{mask: 3'b001, n0: 1, n1: 0, n2: 0, exp_beats: 1, exp_seg: 0};

        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data",  64'(m_data),  64'd0);
        check("rst_m_last",  64'(m_last),  64'd0);
        check("rst_m_seg",   64'(m_seg),   64'd0);
`ifdef DATA_C_FRAME_CONCAT_FCNT_EN
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif

        // Table-driven frames, m_ready held high: beat order, tags, no bubbles.
        for (int v = 0; v < 6; v++) begin
            m_ready = 1'b1;
            do_reset();
            load_frame(vt[v].mask, vt[v].n0, vt[v].n1, vt[v].n2, 32'h1000_0000 * (v + 1));
            repeat (2) @(posedge clock);
            #1;
            seg_mask = vt[v].mask;
            wait_done("table", 50);
            check("tbl_beats",   64'(nbeats), 64'(vt[v].exp_beats));
            check("tbl_lastseg", 64'(last_seg), 64'(vt[v].exp_seg));
            check("tbl_nobubble", 64'(last_cyc - first_cyc), 64'(vt[v].exp_beats - 1));
            check("tbl_heldoff", 64'(saw_ready & ~vt[v].mask), 64'd0);
        end

        // Back-to-back frames; mask change mid-frame applies to the next frame.
        m_ready = 1'b1;
        do_reset();
        load_frame(3'b011, 2, 2, 0, 32'hA000_0000);
        load_frame(3'b001, 3, 0, 0, 32'hB000_0000);
        repeat (2) @(posedge clock);
        #1;
        seg_mask = 3'b011;
        wait_beats(1, 20);
        @(posedge clock);
        #1;
        seg_mask = 3'b001;
        wait_done("b2b", 50);
        check("b2b_beats", 64'(nbeats), 64'd7);
        check("b2b_nogap", 64'(last_cyc - first_cyc), 64'd6);

        // Backpressure: m_ready low, only two beats absorbed, output held.
        m_ready = 1'b0;
        do_reset();
        load_frame(3'b001, 8, 0, 0, 32'hC000_0000);
        repeat (2) @(posedge clock);
        #1;
        seg_mask = 3'b001;
        repeat (8) @(negedge clock);
        check("bp_absorbed", 64'(acc_cnt), 64'd2);
        check("bp_s_ready",  64'(s_ready), 64'd0);
        check("bp_m_valid",  64'(m_valid), 64'd1);
        check("bp_hold_data", 64'(m_data), 64'hC000_0000);
        repeat (3) @(negedge clock);
        check("bp_hold_data2", 64'(m_data), 64'hC000_0000);
        check("bp_absorbed2", 64'(acc_cnt), 64'd2);
        @(posedge clock);
        #1;
        m_ready = 1'b1;
        wait_done("bp", 50);
        check("bp_beats", 64'(nbeats), 64'd8);

        // Reset mid-frame, then a new frame starting at segment 1.
        m_ready = 1'b1;
        do_reset();
        load_frame(3'b111, 2, 4, 1, 32'hD000_0000);
        repeat (2) @(posedge clock);
        #1;
        seg_mask = 3'b111;
        wait_beats(3, 30);
        @(posedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_m_data",  64'(m_data),  64'd0);
        check("mid_rst_m_last",  64'(m_last),  64'd0);
        check("mid_rst_m_seg",   64'(m_seg),   64'd0);
        do_reset();
        load_frame(3'b110, 0, 2, 1, 32'hE000_0000);
        repeat (2) @(posedge clock);
        #1;
        seg_mask = 3'b110;
        wait_done("post_rst", 50);
        check("post_rst_first_seg", 64'(first_seg), 64'd1);
        check("post_rst_beats", 64'(nbeats), 64'd3);

`ifdef DATA_C_FRAME_CONCAT_FCNT_EN
        // 65537 one-beat frames: counter wraps once and lands on 1.
        m_ready = 1'b1;
        do_reset();
        for (int j = 0; j < 65537; j++) begin
            src_q[0].push_back({32'(j), 1'b1});
            exp_q.push_back({32'(j), SW'(0), 1'b1});
        end
        repeat (2) @(posedge clock);
        #1;
        seg_mask = 3'b001;
        wait_done("fcnt", 70000);
        check("frame_cnt_wrap", 64'(frame_cnt), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
